// File: rtl/synth_frame_loader.sv
// synth_frame_loader: turns the MCU control byte stream into framed records,
// validates each frame, and atomically commits complete records into the live
// synth parameter image (voices first, global record last, big-endian bytes).
//
// Handshake: a byte is consumed on every cycle where byte_valid is high; there
// is no backpressure. frame_start/frame_end are single-cycle chip-select
// pulses. commit_o, voice_upd_o, global_upd_o and err_o are single-cycle
// pulses registered on the same edge that updates synth_o.
module synth_frame_loader #(
  parameter int N_OSCILLATORS = 16,
  parameter int ENVELOPE_LEN  = 4,
  parameter int VOICE_BYTES   = 10 + 8*ENVELOPE_LEN,
  parameter int GLOBAL_BYTES  = 38,
  parameter int SYNTH_W       = 8*(N_OSCILLATORS*VOICE_BYTES + GLOBAL_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  input  logic                     frame_start,
  input  logic                     frame_end,
  output logic [SYNTH_W-1:0]       synth_o,
  output logic                     commit_o,
  output logic [N_OSCILLATORS-1:0] voice_upd_o,
  output logic                     global_upd_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [2:0]               state_dbg
);

  localparam int STG_BYTES = (VOICE_BYTES > GLOBAL_BYTES) ? VOICE_BYTES : GLOBAL_BYTES;
  localparam int STG_W     = 8*STG_BYTES;
  localparam int VOICE_W   = 8*VOICE_BYTES;
  localparam int GLOBAL_W  = 8*GLOBAL_BYTES;
  localparam int CNT_W     = $clog2(STG_BYTES + 1);
  localparam int IDX_W     = (N_OSCILLATORS > 1) ? $clog2(N_OSCILLATORS) : 1;

  localparam logic [CNT_W-1:0] VOICE_LEN  = CNT_W'(VOICE_BYTES);
  localparam logic [CNT_W-1:0] GLOBAL_LEN = CNT_W'(GLOBAL_BYTES);
  localparam logic [7:0]       OP_VOICE   = 8'hA1;
  localparam logic [7:0]       OP_GLOBAL  = 8'hA2;
  localparam logic [7:0]       N_VOICES_B = 8'(N_OSCILLATORS);

  // Power-on image: everything zero except each voice's shape byte = SIN (2).
  // The shape byte is the second-to-last byte of each voice record.
  function automatic logic [SYNTH_W-1:0] reset_img();
    logic [SYNTH_W-1:0] img;
    img = '0;
    for (int v = 0; v < N_OSCILLATORS; v++)
      img[SYNTH_W-1-8*(v*VOICE_BYTES + VOICE_BYTES-2) -: 8] = 8'h02;
    return img;
  endfunction

  localparam logic [SYNTH_W-1:0] RESET_IMG = reset_img();

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_INDEX, S_PAYLOAD, S_FULL, S_COMMIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               payload_done;
  logic [STG_W-1:0]   staging;
  logic               tgt_global;
  logic [IDX_W-1:0]   idx;
  logic [VOICE_W-1:0] voice_rec;

  assign busy_o    = (state != S_IDLE);
  assign state_dbg = state;

  // Payload completion test and the voice record with the unused shape bits cleared.
  always_comb begin
    cnt_inc         = cnt + 1'b1;
    payload_done    = (cnt_inc == (tgt_global ? GLOBAL_LEN : VOICE_LEN));
    voice_rec       = staging[VOICE_W-1:0];
    voice_rec[15:10] = '0;
  end

  // Frame FSM, staging shift register and the committed image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      staging      <= '0;
      tgt_global   <= 1'b0;
      idx          <= '0;
      synth_o      <= RESET_IMG;
      commit_o     <= 1'b0;
      voice_upd_o  <= '0;
      global_upd_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      commit_o     <= 1'b0;
      voice_upd_o  <= '0;
      global_upd_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state   <= S_OPCODE;
            cnt     <= '0;
            staging <= '0;
          end
        end
        S_OPCODE: begin
          if (frame_start) begin
            err_o <= 1'b1; state <= S_OPCODE; cnt <= '0; staging <= '0;
          end else if (byte_valid) begin
            if (byte_data == OP_VOICE) begin
              tgt_global <= 1'b0;
              state      <= frame_end ? S_IDLE : S_INDEX;
              err_o      <= frame_end;
            end else if (byte_data == OP_GLOBAL) begin
              tgt_global <= 1'b1;
              state      <= frame_end ? S_IDLE : S_PAYLOAD;
              err_o      <= frame_end;
            end else begin
              err_o <= 1'b1; state <= S_IDLE;
            end
          end else if (frame_end) begin
            err_o <= 1'b1; state <= S_IDLE;
          end
        end
        S_INDEX: begin
          if (frame_start) begin
            err_o <= 1'b1; state <= S_OPCODE; cnt <= '0; staging <= '0;
          end else if (byte_valid) begin
            if (byte_data < N_VOICES_B) begin
              idx   <= byte_data[IDX_W-1:0];
              state <= frame_end ? S_IDLE : S_PAYLOAD;
              err_o <= frame_end;
            end else begin
              err_o <= 1'b1; state <= S_IDLE;
            end
          end else if (frame_end) begin
            err_o <= 1'b1; state <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (frame_start) begin
            err_o <= 1'b1; state <= S_OPCODE; cnt <= '0; staging <= '0;
          end else if (byte_valid) begin
            // The byte is taken first; a coincident frame_end is judged on the result.
            staging <= {staging[STG_W-9:0], byte_data};
            cnt     <= cnt_inc;
            if (payload_done) begin
              state <= frame_end ? S_COMMIT : S_FULL;
            end else if (frame_end) begin
              err_o <= 1'b1; state <= S_IDLE;
            end
          end else if (frame_end) begin
            err_o <= 1'b1; state <= S_IDLE;
          end
        end
        S_FULL: begin
          // A restart here is refused outright: the host must issue a fresh frame_start.
          if (frame_start || byte_valid) begin
            err_o <= 1'b1; state <= S_IDLE;
          end else if (frame_end) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          commit_o <= 1'b1;
          if (tgt_global) begin
            synth_o[GLOBAL_W-1:0] <= staging[GLOBAL_W-1:0];
            global_upd_o          <= 1'b1;
          end else begin
            for (int v = 0; v < N_OSCILLATORS; v++)
              if (idx == IDX_W'(v))
                synth_o[SYNTH_W-1-v*VOICE_W -: VOICE_W] <= voice_rec;
            voice_upd_o[idx] <= 1'b1;
          end
          if (frame_start) begin
            err_o <= 1'b1; state <= S_OPCODE; cnt <= '0; staging <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_frame_loader.sv
// Bench for synth_frame_loader: a table of frames with expected pulses, hand
// sequences for restart/reset corner cases, and random frames checked against
// a byte-array model of the parameter image.
module tb_synth_frame_loader;

  localparam int N   = 16;
  localparam int EL  = 4;
  localparam int VB  = 10 + 8*EL;
  localparam int GB  = 38;
  localparam int TOT = N*VB + GB;
  localparam int SW  = 8*TOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic [SW-1:0] synth_o;
  logic          commit_o;
  logic [N-1:0]  voice_upd_o;
  logic          global_upd_o;
  logic          err_o;
  logic          busy_o;
  logic [2:0]    state_dbg;

  synth_frame_loader #(.N_OSCILLATORS(N), .ENVELOPE_LEN(EL)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .frame_start(frame_start), .frame_end(frame_end), .synth_o(synth_o),
    .commit_o(commit_o), .voice_upd_o(voice_upd_o), .global_upd_o(global_upd_o),
    .err_o(err_o), .busy_o(busy_o), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, n_commit = 0, n_err = 0, n_stray = 0, commit_cyc = -1, end_cyc = -100;
  int exp_commit, exp_err;
  logic [N-1:0] last_vupd;
  logic         last_gupd;
  logic [7:0]   ref_img [TOT];
  logic [7:0]   frame_q [$];
  logic [N:0]   exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_img(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < TOT; k++)
      if (bad < 0 && synth_o[SW-1-8*k -: 8] !== ref_img[k]) bad = k;
    n_checks++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: image byte %0d got 0x%02h expected 0x%02h",
                  name, bad, synth_o[SW-1-8*bad -: 8], ref_img[bad]);
  endtask

  // reference model
  task automatic model_reset();
    for (int k = 0; k < TOT; k++) ref_img[k] = 8'h00;
    for (int v = 0; v < N; v++) ref_img[v*VB + VB-2] = 8'h02;
    exp_q.delete();
  endtask

  // Judge the whole frame by its length and header, then apply it.
  task automatic model_frame();
    int sz;
    sz = frame_q.size();
    exp_commit = 0;
    exp_err    = 1;
    if (sz == 1+GB && frame_q[0] == 8'hA2) begin
      for (int i = 0; i < GB; i++) ref_img[N*VB + i] = frame_q[1+i];
      exp_q.push_back({1'b1, {N{1'b0}}});
      exp_commit = 1;
      exp_err    = 0;
    end else if (sz == 2+VB && frame_q[0] == 8'hA1 && frame_q[1] < N) begin
      int v;
      v = frame_q[1];
      for (int i = 0; i < VB; i++) ref_img[v*VB + i] = frame_q[2+i];
      ref_img[v*VB + VB-2] = ref_img[v*VB + VB-2] & 8'h03;
      exp_q.push_back({1'b0, (N'(1) << v)});
      exp_commit = 1;
      exp_err    = 0;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (commit_o) begin
      n_commit++;
      commit_cyc = cyc;
      last_vupd  = voice_upd_o;
      last_gupd  = global_upd_o;
      if (exp_q.size() > 0) chk("upd_pulse", {global_upd_o, voice_upd_o}, exp_q.pop_front());
    end else if (global_upd_o || (|voice_upd_o)) begin
      n_stray++;
    end
    if (err_o) n_err++;
  endtask

  task automatic clr_mon();
    n_commit = 0; n_err = 0; n_stray = 0; commit_cyc = -1; end_cyc = -100;
    last_vupd = '0; last_gupd = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    tick();
    end_cyc = cyc;
    frame_end = 1'b0;
  endtask

  task automatic send_bytes(input bit coinc, input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      byte_data  = frame_q[i];
      byte_valid = 1'b1;
      frame_end  = coinc && (i == frame_q.size()-1);
      tick();
      if (frame_end) end_cyc = cyc;
      byte_valid = 1'b0;
      frame_end  = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic run_frame(input bit coinc, input bit gaps);
    clr_mon();
    pulse_start();
    send_bytes(coinc, gaps);
    if (!coinc || frame_q.size() == 0) pulse_end();
    repeat (4) tick();
  endtask

  task automatic check_frame(input string name);
    chk({name, "_stray_upd"}, n_stray, 0);
    chk({name, "_exp_q_empty"}, exp_q.size(), 0);
    chk_img({name, "_img"});
    chk({name, "_busy"}, busy_o, 1'b0);
    if (n_commit > 0) chk({name, "_latency"}, commit_cyc - end_cyc, 1);
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // vector table
  typedef struct {
    string        name;
    logic [7:0]   op;
    bit           has_op;
    logic [7:0]   idx;
    bit           has_idx;
    int           n_pay;
    bit           coinc;
    logic [31:0]  head;
    bit           use_head;
    int           e_commit;
    int           e_err;
    logic [N-1:0] e_vupd;
    bit           e_gupd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{"voice5",       8'hA1, 1, 8'h05, 1, VB,   0, 32'h00001000, 1, 1, 0, 16'h0020, 0};
    tbl[1]  = '{"global",       8'hA2, 1, 8'h00, 0, GB,   0, 32'h12345678, 1, 1, 0, 16'h0000, 1};
    tbl[2]  = '{"short",        8'hA1, 1, 8'h03, 1, 20,   0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[3]  = '{"bad_index",    8'hA1, 1, 8'h10, 1, 0,    0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[4]  = '{"bad_opcode",   8'h7F, 1, 8'h00, 0, 0,    0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[5]  = '{"overlong",     8'hA1, 1, 8'h02, 1, 49,   0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[6]  = '{"coinc_v15",    8'hA1, 1, 8'h0F, 1, VB,   1, 32'h0,        0, 1, 0, 16'h8000, 0};
    tbl[7]  = '{"voice0",       8'hA1, 1, 8'h00, 1, VB,   0, 32'h0,        0, 1, 0, 16'h0001, 0};
    tbl[8]  = '{"global_long",  8'hA2, 1, 8'h00, 0, GB+1, 0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[9]  = '{"empty",        8'h00, 0, 8'h00, 0, 0,    0, 32'h0,        0, 0, 1, 16'h0000, 0};
    tbl[10] = '{"coinc_global", 8'hA2, 1, 8'h00, 0, GB,   1, 32'h0,        0, 1, 0, 16'h0000, 1};
    tbl[11] = '{"coinc_short",  8'hA2, 1, 8'h00, 0, GB-1, 1, 32'h0,        0, 0, 1, 16'h0000, 0};

    // reset
    model_reset();
    repeat (3) tick();
    chk_img("reset_img");
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_pulses", {commit_o, err_o, global_upd_o, voice_upd_o}, '0);
    rst = 1'b0;
    tick();

    // table-driven frames
    for (int r = 0; r < 12; r++) begin
      logic [31:0] h;
      h = tbl[r].head;
      frame_q.delete();
      if (tbl[r].has_op)  frame_q.push_back(tbl[r].op);
      if (tbl[r].has_idx) frame_q.push_back(tbl[r].idx);
      for (int i = 0; i < tbl[r].n_pay; i++)
        if (tbl[r].use_head && i < 4) frame_q.push_back(h[31-8*i -: 8]);
        else frame_q.push_back(8'($urandom_range(0, 255)));
      model_frame();
      run_frame(tbl[r].coinc, 1'b0);
      chk({tbl[r].name, "_commits"}, n_commit, tbl[r].e_commit);
      chk({tbl[r].name, "_errs"}, n_err, tbl[r].e_err);
      if (tbl[r].e_commit > 0) begin
        chk({tbl[r].name, "_vupd"}, last_vupd, tbl[r].e_vupd);
        chk({tbl[r].name, "_gupd"}, last_gupd, tbl[r].e_gupd);
      end
      check_frame(tbl[r].name);
      if (r == 0) begin
        chk("v5_freq", synth_o[SW-1-8*(5*VB) -: 32], 32'h00001000);
        chk("v4_freq", synth_o[SW-1-8*(4*VB) -: 32], 32'h0);
        chk("v4_shape", synth_o[SW-1-8*(4*VB+VB-2) -: 8], 8'h02);
        chk("v6_shape", synth_o[SW-1-8*(6*VB+VB-2) -: 8], 8'h02);
      end
      if (r == 1) chk("volume", synth_o[8*GB-1 -: 32], 32'h12345678);
    end

    // frame_start mid-payload restarts; only the second frame commits
    clr_mon();
    frame_q = '{8'hA1, 8'h02};
    rand_bytes(10);
    pulse_start();
    send_bytes(1'b0, 1'b0);
    frame_q = '{8'hA1, 8'h07};
    rand_bytes(VB);
    model_frame();
    pulse_start();
    send_bytes(1'b0, 1'b0);
    pulse_end();
    repeat (4) tick();
    chk("restart_errs", n_err, 1);
    chk("restart_commits", n_commit, 1);
    chk("restart_vupd", last_vupd, 16'h0080);
    check_frame("restart");

    // frame_start in FULL: error, and the following bytes are not a frame
    clr_mon();
    frame_q = '{8'hA2};
    rand_bytes(GB);
    pulse_start();
    send_bytes(1'b0, 1'b0);
    pulse_start();
    frame_q = '{8'hA1, 8'h01};
    rand_bytes(VB);
    send_bytes(1'b0, 1'b0);
    pulse_end();
    repeat (4) tick();
    chk("full_restart_errs", n_err, 1);
    chk("full_restart_commits", n_commit, 0);
    check_frame("full_restart");
    model_frame();
    run_frame(1'b0, 1'b0);
    chk("after_full_commits", n_commit, 1);
    check_frame("after_full");

    // frame_start with a byte in the same cycle: the byte is dropped
    clr_mon();
    frame_q = '{8'hA2};
    rand_bytes(GB);
    model_frame();
    frame_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA1;
    tick();
    frame_start = 1'b0; byte_valid = 1'b0;
    send_bytes(1'b0, 1'b0);
    pulse_end();
    repeat (4) tick();
    chk("start_byte_commits", n_commit, 1);
    chk("start_byte_errs", n_err, 0);
    chk("start_byte_gupd", last_gupd, 1'b1);
    check_frame("start_byte");

    // randomized frames
    for (int t = 0; t < 40; t++) begin
      int kind;
      string nm;
      kind = $urandom_range(0, 5);
      frame_q.delete();
      case (kind)
        0: begin frame_q.push_back(8'hA1); frame_q.push_back(8'($urandom_range(0, N-1))); rand_bytes(VB); end
        1: begin frame_q.push_back(8'hA2); rand_bytes(GB); end
        2: begin frame_q.push_back(8'hA1); frame_q.push_back(8'($urandom_range(0, N-1))); rand_bytes($urandom_range(0, VB-1)); end
        3: begin frame_q.push_back(8'hA1); frame_q.push_back(8'($urandom_range(0, N-1))); rand_bytes($urandom_range(VB+1, VB+4)); end
        4: begin rand_bytes(1); rand_bytes($urandom_range(0, 4)); end
        default: begin frame_q.push_back(8'hA1); frame_q.push_back(8'($urandom_range(N, 255))); rand_bytes(3); end
      endcase
      model_frame();
      run_frame(1'($urandom_range(0, 1)), 1'b1);
      nm = $sformatf("rand%0d_k%0d", t, kind);
      chk({nm, "_commits"}, n_commit, exp_commit);
      chk({nm, "_errs"}, n_err, exp_err);
      check_frame(nm);
    end

    // asynchronous reset mid-frame abandons the frame and restores the image
    clr_mon();
    frame_q = '{8'hA1, 8'h03};
    rand_bytes(10);
    pulse_start();
    send_bytes(1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    chk_img("midreset_img");
    chk("midreset_busy", busy_o, 1'b0);
    chk("midreset_pulses", {commit_o, err_o, global_upd_o, voice_upd_o}, '0);
    tick();
    rst = 1'b0;
    tick();
    frame_q.delete();
    rand_bytes(VB - 10);
    send_bytes(1'b0, 1'b0);
    pulse_end();
    repeat (4) tick();
    chk("midreset_commits", n_commit, 0);
    chk("midreset_errs", n_err, 0);
    check_frame("midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
